// File: rtl/key_led_mode_pkg.sv
// Shared constants for the key-driven LED controller: key event codes, mode codes, LED fills.
// MODE_PINGPONG is only reachable when KEY_LED_MODE_PINGPONG_EN is defined.
package key_led_pkg;

   localparam logic [3:0] KEY_NONE = 4'b0000;
   localparam logic [3:0] KEY_S1   = 4'b0001;
   localparam logic [3:0] KEY_S2   = 4'b0010;
   localparam logic [3:0] KEY_S3   = 4'b0100;
   localparam logic [3:0] KEY_S4   = 4'b1000;

   localparam logic [2:0] MODE_OFF       = 3'd0;
   localparam logic [2:0] MODE_RUN_LEFT  = 3'd1;
   localparam logic [2:0] MODE_RUN_RIGHT = 3'd2;
   localparam logic [2:0] MODE_BLINK     = 3'd3;
   localparam logic [2:0] MODE_PINGPONG  = 3'd4;

   localparam logic [7:0] LED_ALL_OFF = 8'hFF;
   localparam logic [7:0] LED_ALL_ON  = 8'h00;

   function automatic logic [2:0] next_mode(input logic [2:0] m);
      case (m)
         MODE_OFF:       next_mode = MODE_RUN_LEFT;
         MODE_RUN_LEFT:  next_mode = MODE_RUN_RIGHT;
         MODE_RUN_RIGHT: next_mode = MODE_BLINK;
`ifdef KEY_LED_MODE_PINGPONG_EN
         MODE_BLINK:     next_mode = MODE_PINGPONG;
`else
         MODE_BLINK:     next_mode = MODE_OFF;
`endif
         default:        next_mode = MODE_OFF;
      endcase
   endfunction

   // Single lit LED at pos on an active-low bank.
   function automatic logic [7:0] one_cold(input logic [2:0] pos);
      one_cold = ~(8'h01 << pos);
   endfunction

endpackage

// File: rtl/key_led_mode_if.sv
// Control/step channel between the mode FSM (master) and the tick/step generator (slave).
interface key_led_mode_if;
   logic       clr;
   logic       clr_step;
   logic       hold;
   logic [1:0] speed;
   logic       step;

   modport master (output clr, output clr_step, output hold, output speed, input step);
   modport slave  (input clr, input clr_step, input hold, input speed, output step);
endinterface

// File: rtl/key_led_mode_tick.sv
// Base tick divider plus step-period counter (8>>speed ticks per step); emits a one-cycle step.
module key_led_tick #(
   parameter int unsigned TICK_MAX = 2_500_000
) (
   input  logic          clk,
   input  logic          rst,
   key_led_mode_if.slave ctl
);
   import key_led_pkg::*;

   localparam int unsigned   CW        = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_MAX - 1);

   logic [CW-1:0] tick_cnt_q, tick_cnt_d;
   logic [2:0]    step_cnt_q, step_cnt_d;
   logic [2:0]    period_m1;
   logic          tick;

   assign tick      = (tick_cnt_q == TICK_LAST);
   assign period_m1 = 3'((4'd8 >> ctl.speed) - 4'd1);
   assign ctl.step  = !ctl.clr && !ctl.clr_step && !ctl.hold && tick && (step_cnt_q == period_m1);

   always_comb begin
      tick_cnt_d = tick_cnt_q;
      step_cnt_d = step_cnt_q;
      if (ctl.clr) begin
         tick_cnt_d = '0;
      end else if (!ctl.hold) begin
         tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      end
      // A step-count clear applies even while held so a new speed starts a fresh period on resume.
      if (ctl.clr || ctl.clr_step) begin
         step_cnt_d = '0;
      end else if (!ctl.hold && tick) begin
         step_cnt_d = (step_cnt_q == period_m1) ? 3'd0 : step_cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tick_cnt_q <= '0;
         step_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         step_cnt_q <= step_cnt_d;
      end
   end

endmodule

// File: rtl/key_led_mode.sv
// Key-event driven running-light / blink LED controller with mode, speed and pause (LEDs active-low).
// Define KEY_LED_MODE_PINGPONG_EN to add the PINGPONG mode after BLINK.
module key_led_mode #(
   parameter int unsigned TICK_MAX = 2_500_000,
   parameter int unsigned LED_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       key_pulse,
   output logic [LED_W-1:0] led,
   output logic [2:0]       mode,
   output logic [1:0]       speed,
   output logic             paused
);
   import key_led_pkg::*;

   logic [7:0] led_q, led_d;
   logic [2:0] mode_q, mode_d;
   logic [1:0] speed_q, speed_d;
   logic       paused_q, paused_d;
   logic [2:0] pos_q, pos_d;
   logic       phase_q, phase_d;
`ifdef KEY_LED_MODE_PINGPONG_EN
   logic       dir_q, dir_d;
`endif
   logic       key_s1, key_s2, key_s3, key_s4;
   logic       step;

   key_led_mode_if tick_if ();

   key_led_tick #(.TICK_MAX(TICK_MAX)) u_tick (
      .clk (clk),
      .rst (rst),
      .ctl (tick_if)
   );

   // Exact compares: multi-hot codes match nothing and are ignored.
   assign key_s1 = (key_pulse == KEY_S1);
   assign key_s2 = (key_pulse == KEY_S2);
   assign key_s3 = (key_pulse == KEY_S3);
   assign key_s4 = (key_pulse == KEY_S4);

   assign tick_if.clr      = (mode_q == MODE_OFF) || key_s1 || key_s4;
   assign tick_if.clr_step = key_s2;
   assign tick_if.hold     = paused_q;
   assign tick_if.speed    = speed_q;
   assign step             = tick_if.step;

   always_comb begin
      mode_d   = mode_q;
      speed_d  = speed_q;
      paused_d = paused_q;
      pos_d    = pos_q;
      phase_d  = phase_q;
`ifdef KEY_LED_MODE_PINGPONG_EN
      dir_d    = dir_q;
`endif
      // Key events take priority; a coincident step is dropped.
      if (key_s1) begin
         mode_d   = next_mode(mode_q);
         paused_d = 1'b0;
         phase_d  = 1'b0;
         pos_d    = (mode_d == MODE_RUN_RIGHT) ? 3'd7 : 3'd0;
`ifdef KEY_LED_MODE_PINGPONG_EN
         dir_d    = 1'b1;
`endif
      end else if (key_s2) begin
         speed_d = speed_q + 2'd1;
      end else if (key_s3) begin
         if (mode_q != MODE_OFF) paused_d = ~paused_q;
      end else if (key_s4) begin
         mode_d   = MODE_OFF;
         paused_d = 1'b0;
         pos_d    = 3'd0;
         phase_d  = 1'b0;
      end else if (step) begin
         case (mode_q)
            MODE_RUN_LEFT:  pos_d   = pos_q + 3'd1;
            MODE_RUN_RIGHT: pos_d   = pos_q - 3'd1;
            MODE_BLINK:     phase_d = ~phase_q;
`ifdef KEY_LED_MODE_PINGPONG_EN
            MODE_PINGPONG: begin
               if (dir_q) begin
                  if (pos_q == 3'd7) begin
                     pos_d = 3'd6;
                     dir_d = 1'b0;
                  end else begin
                     pos_d = pos_q + 3'd1;
                  end
               end else begin
                  if (pos_q == 3'd0) begin
                     pos_d = 3'd1;
                     dir_d = 1'b1;
                  end else begin
                     pos_d = pos_q - 3'd1;
                  end
               end
            end
`endif
            default: ;
         endcase
      end

      case (mode_d)
         MODE_OFF:   led_d = LED_ALL_OFF;
         MODE_BLINK: led_d = phase_d ? LED_ALL_OFF : LED_ALL_ON;
         default:    led_d = one_cold(pos_d);
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         led_q    <= LED_ALL_OFF;
         mode_q   <= MODE_OFF;
         speed_q  <= 2'd0;
         paused_q <= 1'b0;
         pos_q    <= 3'd0;
         phase_q  <= 1'b0;
`ifdef KEY_LED_MODE_PINGPONG_EN
         dir_q    <= 1'b1;
`endif
      end else begin
         led_q    <= led_d;
         mode_q   <= mode_d;
         speed_q  <= speed_d;
         paused_q <= paused_d;
         pos_q    <= pos_d;
         phase_q  <= phase_d;
`ifdef KEY_LED_MODE_PINGPONG_EN
         dir_q    <= dir_d;
`endif
      end
   end

   assign led    = led_q;
   assign mode   = mode_q;
   assign speed  = speed_q;
   assign paused = paused_q;

endmodule
